// File: rtl/cart_mem_bridge_if.sv
// rtl/cart_mem_bridge_if.sv - CPU bus, SDRAM and SRAM BRAM signals of the cartridge memory bridge
interface cart_mem_bridge_if #(
    parameter int SRAM_AW = 15
);
    logic               cs;
    logic               mreq;
    logic               rd;
    logic               wr;
    logic [24:0]        mem_addr;
    logic               sram_oe;
    logic               sram_we;
    logic [2:0]         sram_size;
    logic [7:0]         d_from_cpu;
    logic [24:0]        sdram_addr;
    logic               sdram_rd;
    logic               sdram_ready;
    logic [7:0]         sdram_q;
    logic [SRAM_AW-1:0] bram_addr;
    logic [7:0]         bram_din;
    logic               bram_we;
    logic [7:0]         bram_q;
    logic [7:0]         d_to_cpu;
    logic               cart_oe;
    logic               wait_n;

    modport slave (
        input  cs, mreq, rd, wr, mem_addr, sram_oe, sram_we, sram_size, d_from_cpu,
        input  sdram_ready, sdram_q, bram_q,
        output sdram_addr, sdram_rd, bram_addr, bram_din, bram_we,
        output d_to_cpu, cart_oe, wait_n
    );

    modport master (
        output cs, mreq, rd, wr, mem_addr, sram_oe, sram_we, sram_size, d_from_cpu,
        output sdram_ready, sdram_q, bram_q,
        input  sdram_addr, sdram_rd, bram_addr, bram_din, bram_we,
        input  d_to_cpu, cart_oe, wait_n
    );
endinterface

// File: rtl/cart_mem_bridge.sv
// rtl/cart_mem_bridge.sv - turns mapped Z80 cartridge accesses into SDRAM ROM reads and BRAM SRAM accesses
module cart_mem_bridge #(
    parameter int          SRAM_AW  = 15,
    parameter int          TIMEOUT  = 64,
    parameter logic [24:0] ROM_BASE = 25'h0000000
) (
    input  logic            clk,
    input  logic            reset,
    cart_mem_bridge_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        RREQ,
        RWAIT,
        SR1,
        SR2,
        SW,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [24:0]        sdram_addr_q, sdram_addr_d;
    logic               sdram_rd_q, sdram_rd_d;
    logic [SRAM_AW-1:0] bram_addr_q, bram_addr_d;
    logic [7:0]         bram_din_q, bram_din_d;
    logic               bram_we_q, bram_we_d;
    logic [7:0]         d_to_cpu_q, d_to_cpu_d;
    logic               cart_oe_q, cart_oe_d;
    logic               wait_n_q, wait_n_d;

    logic               acc;
    logic               start;
    logic [4:0]         sram_blk;
    logic               sram_hit;
    logic [SRAM_AW-1:0] sram_mask;
    logic               rd_stall;
    logic               fin;
    logic [7:0]         fin_data;

    assign acc      = bus.cs & bus.mreq & (bus.rd | bus.wr);
    assign start    = acc & ~acc_q;
    assign sram_blk = bus.mem_addr[14:10] >> (bus.sram_size - 3'd1);
    assign sram_hit = (bus.sram_size != 3'd0) && (sram_blk == 5'd0);
    // Window of 2^(size+9) bytes; sizes of 32 KB and above keep every address bit.
    assign sram_mask = ~({SRAM_AW{1'b1}} << ({1'b0, bus.sram_size} + 4'd9));

    // Reads that will stall must pull WAIT low in the start cycle itself so T2 sees it.
    assign rd_stall = (state_q == IDLE) & start & bus.rd & ~(bus.sram_oe & ~sram_hit);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc;
        cnt_d        = cnt_q + CW'(1);
        sdram_addr_d = sdram_addr_q;
        sdram_rd_d   = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_din_d   = bram_din_q;
        bram_we_d    = 1'b0;
        d_to_cpu_d   = d_to_cpu_q;
        cart_oe_d    = cart_oe_q;
        wait_n_d     = wait_n_q;
        fin          = 1'b0;
        fin_data     = 8'hFF;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bus.rd) begin
                        if (bus.sram_oe && sram_hit) begin
                            state_d     = SR1;
                            bram_addr_d = bus.mem_addr[SRAM_AW-1:0] & sram_mask;
                            wait_n_d    = 1'b0;
                        end else if (bus.sram_oe) begin
                            fin      = 1'b1;
                            fin_data = 8'hFF;
                        end else begin
                            state_d      = RREQ;
                            sdram_addr_d = bus.mem_addr + ROM_BASE;
                            sdram_rd_d   = 1'b1;
                            wait_n_d     = 1'b0;
                        end
                    end else if (bus.sram_we && sram_hit) begin
                        state_d     = SW;
                        bram_addr_d = bus.mem_addr[SRAM_AW-1:0] & sram_mask;
                        bram_din_d  = bus.d_from_cpu;
                        bram_we_d   = 1'b1;
                    end
                end
            end
            RREQ: begin
                state_d = RWAIT;
            end
            RWAIT: begin
                if (bus.sdram_ready) begin
                    fin      = 1'b1;
                    fin_data = bus.sdram_q;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    fin      = 1'b1;
                    fin_data = 8'hFF;
                end
            end
            SR1: begin
                state_d = SR2;
            end
            SR2: begin
                fin      = 1'b1;
                fin_data = bus.bram_q;
            end
            SW: begin
                state_d = IDLE;
            end
            DONE: begin
                if (!acc) begin
                    state_d    = IDLE;
                    cart_oe_d  = 1'b0;
                    d_to_cpu_d = 8'hFF;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A CPU that dropped its strobe mid-access never gets the bus driven.
        if (fin) begin
            wait_n_d = 1'b1;
            if (acc) begin
                state_d    = DONE;
                cart_oe_d  = 1'b1;
                d_to_cpu_d = fin_data;
            end else begin
                state_d = IDLE;
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            sdram_addr_q <= '0;
            sdram_rd_q   <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            bram_we_q    <= 1'b0;
            d_to_cpu_q   <= 8'hFF;
            cart_oe_q    <= 1'b0;
            wait_n_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_rd_q   <= sdram_rd_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
            bram_we_q    <= bram_we_d;
            d_to_cpu_q   <= d_to_cpu_d;
            cart_oe_q    <= cart_oe_d;
            wait_n_q     <= wait_n_d;
        end
    end

    assign bus.sdram_addr = sdram_addr_q;
    assign bus.sdram_rd   = sdram_rd_q;
    assign bus.bram_addr  = bram_addr_q;
    assign bus.bram_din   = bram_din_q;
    assign bus.bram_we    = bram_we_q;
    assign bus.d_to_cpu   = d_to_cpu_q;
    assign bus.cart_oe    = cart_oe_q;
    assign bus.wait_n     = wait_n_q & ~(rd_stall & ~reset);
endmodule

// File: tb/tb_cart_mem_bridge.sv
// tb/tb_cart_mem_bridge.sv - randomized bench for cart_mem_bridge against a transaction-level model
module tb_cart_mem_bridge;
    localparam int          SRAM_AW  = 15;
    localparam int          TIMEOUT  = 64;
    localparam logic [24:0] ROM_BASE = 25'h0000000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cart_mem_bridge_if #(.SRAM_AW(SRAM_AW)) bus ();

    cart_mem_bridge #(
        .SRAM_AW (SRAM_AW),
        .TIMEOUT (TIMEOUT),
        .ROM_BASE(ROM_BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]         bram_mem [0:32767];
    logic [7:0]         ref_sram [0:32767];
    int                 rdy_delay = 0;
    logic [7:0]         rdy_data  = 8'h00;
    int                 n_srd = 0;
    int                 n_bwe = 0;
    logic [24:0]        cap_saddr;
    logic [SRAM_AW-1:0] cap_baddr;
    logic [7:0]         cap_bdin;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.sdram_rd) begin
                n_srd++;
                cap_saddr = bus.sdram_addr;
            end
            if (bus.bram_we) begin
                n_bwe++;
                cap_baddr = bus.bram_addr;
                cap_bdin  = bus.bram_din;
            end
        end
    end

    // Registered single-port BRAM: address seen in cycle k gives data in cycle k+1.
    initial begin
        logic [SRAM_AW-1:0] a;
        logic               we;
        logic [7:0]         d;
        bus.bram_q = 8'h00;
        forever begin
            @(negedge clk);
            a  = bus.bram_addr;
            we = bus.bram_we;
            d  = bus.bram_din;
            @(posedge clk);
            #1;
            bus.bram_q = bram_mem[a];
            if (we) bram_mem[a] = d;
        end
    end

    // SDRAM: ready pulse rdy_delay cycles after the cycle carrying sdram_rd; 0 means never.
    initial begin
        bus.sdram_ready = 1'b0;
        bus.sdram_q     = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (bus.sdram_rd && rdy_delay > 0) begin
                repeat (rdy_delay) @(posedge clk);
                #1;
                bus.sdram_ready = 1'b1;
                bus.sdram_q     = rdy_data;
                @(posedge clk);
                #1;
                bus.sdram_ready = 1'b0;
                bus.sdram_q     = 8'($urandom);
            end
        end
    end

    function automatic int sram_bytes(input logic [2:0] size);
        return (size == 3'd0) ? 0 : (512 << size);
    endfunction

    task automatic do_read(input logic [24:0] a, input logic oe, input logic [2:0] size,
                           input int delay, input logic [7:0] sdq, input int hold);
        int          bytes, wl, cyc, exp_wl, exp_srd;
        logic        hit;
        logic [7:0]  exp_d;
        logic [24:0] exp_sa;
        bytes  = sram_bytes(size);
        hit    = (size != 3'd0) && (int'(a[14:0]) < bytes);
        exp_sa = a + ROM_BASE;
        if (oe && !hit) begin
            exp_d = 8'hFF; exp_wl = 0; exp_srd = 0;
        end else if (oe) begin
            exp_d = ref_sram[int'(a[14:0]) % bytes]; exp_wl = 3; exp_srd = 0;
        end else if (delay >= 1 && delay <= TIMEOUT) begin
            exp_d = sdq; exp_wl = 2 + delay; exp_srd = 1;
        end else begin
            exp_d = 8'hFF; exp_wl = 2 + TIMEOUT; exp_srd = 1;
        end
        @(posedge clk);
        #1;
        rdy_delay = delay;
        rdy_data  = sdq;
        n_srd = 0;
        n_bwe = 0;
        bus.mem_addr  = a;
        bus.sram_oe   = oe;
        bus.sram_we   = 1'b0;
        bus.sram_size = size;
        bus.cs = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1;
        wl  = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            if (!bus.wait_n) wl++;
            cyc++;
        end while (!bus.cart_oe && cyc < 200);
        check("rd_cart_oe", bus.cart_oe, 1);
        check("rd_data", bus.d_to_cpu, exp_d);
        check("rd_wait_cycles", wl, exp_wl);
        check("rd_wait_n_released", bus.wait_n, 1);
        check("rd_sdram_pulses", n_srd, exp_srd);
        if (exp_srd == 1) check("rd_sdram_addr", cap_saddr, exp_sa);
        check("rd_bram_we", n_bwe, 0);
        repeat (hold) @(negedge clk);
        check("rd_hold_data", bus.d_to_cpu, exp_d);
        check("rd_hold_oe", bus.cart_oe, 1);
        @(posedge clk);
        #1;
        bus.rd = 1'b0; bus.cs = 1'b0; bus.mreq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rd_release_oe", bus.cart_oe, 0);
        check("rd_release_data", bus.d_to_cpu, 8'hFF);
    endtask

    task automatic do_write(input logic [24:0] a, input logic we, input logic [2:0] size,
                            input logic [7:0] d);
        int                 bytes, wl;
        logic               hit, exp_we;
        logic [SRAM_AW-1:0] exp_ba;
        bytes  = sram_bytes(size);
        hit    = (size != 3'd0) && (int'(a[14:0]) < bytes);
        exp_we = we && hit;
        exp_ba = hit ? SRAM_AW'(int'(a[14:0]) % bytes) : '0;
        @(posedge clk);
        #1;
        rdy_delay = 0;
        n_srd = 0;
        n_bwe = 0;
        bus.mem_addr   = a;
        bus.sram_oe    = 1'b0;
        bus.sram_we    = we;
        bus.sram_size  = size;
        bus.d_from_cpu = d;
        bus.cs = 1'b1; bus.mreq = 1'b1; bus.wr = 1'b1;
        wl = 0;
        repeat (4) begin
            @(negedge clk);
            if (!bus.wait_n) wl++;
        end
        check("wr_wait_cycles", wl, 0);
        check("wr_bram_we", n_bwe, exp_we ? 1 : 0);
        if (exp_we) begin
            check("wr_bram_addr", cap_baddr, exp_ba);
            check("wr_bram_din", cap_bdin, d);
            ref_sram[exp_ba] = d;
        end
        check("wr_sdram_pulses", n_srd, 0);
        check("wr_cart_oe", bus.cart_oe, 0);
        @(posedge clk);
        #1;
        bus.wr = 1'b0; bus.cs = 1'b0; bus.mreq = 1'b0; bus.sram_we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int               oe_cnt, k, hold;
        logic [2:0]       size;
        logic [24:0]      a;
        for (int i = 0; i < 32768; i++) begin
            bram_mem[i] = 8'(i * 7 + 3);
            ref_sram[i] = 8'(i * 7 + 3);
        end
        bus.cs = 1'b0; bus.mreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        bus.mem_addr = '0; bus.sram_oe = 1'b0; bus.sram_we = 1'b0;
        bus.sram_size = 3'd0; bus.d_from_cpu = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_wait_n", bus.wait_n, 1);
        check("rst_cart_oe", bus.cart_oe, 0);
        check("rst_d_to_cpu", bus.d_to_cpu, 8'hFF);
        check("rst_sdram_rd", bus.sdram_rd, 0);
        check("rst_bram_we", bus.bram_we, 0);
        check("rst_sdram_addr", bus.sdram_addr, 0);
        check("rst_bram_addr", bus.bram_addr, 0);
        check("rst_bram_din", bus.bram_din, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        do_read(25'h0012345, 1'b0, 3'd0, 4, 8'hA5, 2);
        do_write(25'h0001FFF, 1'b1, 3'd4, 8'h3C);
        do_read(25'h0001FFF, 1'b1, 3'd4, 0, 8'h00, 1);
        do_read(25'h0002000, 1'b1, 3'd4, 0, 8'h00, 1);
        do_write(25'h0002000, 1'b1, 3'd4, 8'h77);
        do_read(25'h0000100, 1'b1, 3'd0, 0, 8'h00, 0);
        do_write(25'h0007FFF, 1'b1, 3'd6, 8'h5E);
        do_read(25'h1F07FFF, 1'b1, 3'd6, 0, 8'h00, 0);
        do_write(25'h0000400, 1'b1, 3'd1, 8'h99);
        do_read(25'h00003FF, 1'b1, 3'd1, 0, 8'h00, 0);
        do_read(25'h1FFFFFF, 1'b0, 3'd0, 0, 8'h12, 3);
        do_read(25'h0000040, 1'b0, 3'd0, TIMEOUT, 8'h6B, 1);
        do_read(25'h0000041, 1'b0, 3'd0, TIMEOUT + 1, 8'h6C, 10);
        do_read(25'h0000042, 1'b0, 3'd0, 80, 8'h6D, 25);
        do_write(25'h1234567, 1'b0, 3'd4, 8'h11);

        // Strobe dropped while the SDRAM read is in flight.
        @(posedge clk);
        #1;
        rdy_delay = 6; rdy_data = 8'h42; n_srd = 0;
        bus.mem_addr = 25'h0000777; bus.sram_oe = 1'b0; bus.sram_size = 3'd0;
        bus.cs = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.rd = 1'b0; bus.cs = 1'b0; bus.mreq = 1'b0;
        oe_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.cart_oe) oe_cnt++;
        end
        check("abort_cart_oe_cycles", oe_cnt, 0);
        check("abort_sdram_pulses", n_srd, 1);
        check("abort_wait_n", bus.wait_n, 1);
        check("abort_d_to_cpu", bus.d_to_cpu, 8'hFF);

        // Reset while waiting on an SDRAM read that never answers.
        @(posedge clk);
        #1;
        rdy_delay = 0; n_srd = 0;
        bus.mem_addr = 25'h0000888; bus.sram_oe = 1'b0;
        bus.cs = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_wait_n", bus.wait_n, 0);
        reset = 1'b1;
        bus.rd = 1'b0; bus.cs = 1'b0; bus.mreq = 1'b0;
        #1;
        check("midreset_wait_n", bus.wait_n, 1);
        check("midreset_cart_oe", bus.cart_oe, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        n_srd = 0;
        repeat (5) @(negedge clk);
        check("post_reset_no_reissue", n_srd, 0);
        do_read(25'h0000999, 1'b0, 3'd0, 3, 8'hC7, 1);

        for (int i = 0; i < 60; i++) begin
            k    = $urandom_range(0, 3);
            size = 3'($urandom_range(0, 6));
            hold = $urandom_range(0, 3);
            a    = 25'($urandom);
            if (k != 0) a[14:0] = 15'($urandom_range(0, (size == 3'd0) ? 1023 : (1024 << size) - 1));
            case (k)
                0: do_read(a, 1'b0, size, $urandom_range(1, 10), 8'($urandom), hold);
                1: do_read(a, 1'b1, size, 0, 8'h00, hold);
                2: do_write(a, 1'b1, size, 8'($urandom));
                default: do_write(a, 1'b0, size, 8'($urandom));
            endcase
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
